// File: rtl/voice_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | voice_pkg : shared types and pitch table for the voice_ctrl front end      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package voice_pkg;

  localparam int NOTE_W   = 7;
  localparam int FREQ_W   = 24;
  localparam int BASE_OCT = 10;

  // Phase increments for the top octave (notes 120..131); lower octaves shift right.
  localparam logic [FREQ_W-1:0] SEMI_INC [12] = '{
    24'd2926233, 24'd3100235, 24'd3284585, 24'd3479896,
    24'd3686822, 24'd3906052, 24'd4138318, 24'd4384395,
    24'd4645104, 24'd4921317, 24'd5213953, 24'd5523991
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic logic [FREQ_W-1:0] semi_inc(input logic [3:0] k);
    case (k)
      4'd0:    return SEMI_INC[0];
      4'd1:    return SEMI_INC[1];
      4'd2:    return SEMI_INC[2];
      4'd3:    return SEMI_INC[3];
      4'd4:    return SEMI_INC[4];
      4'd5:    return SEMI_INC[5];
      4'd6:    return SEMI_INC[6];
      4'd7:    return SEMI_INC[7];
      4'd8:    return SEMI_INC[8];
      4'd9:    return SEMI_INC[9];
      4'd10:   return SEMI_INC[10];
      4'd11:   return SEMI_INC[11];
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/voice_ctrl_note_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_stack : last-note-priority stack, entry 0 is the sounding note        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module note_stack
  import voice_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on_i,
  input  logic              off_i,
  input  logic [NOTE_W-1:0] note_i,
  output logic [NOTE_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [NOTE_W-1:0] stk_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;

  logic [DEPTH-1:0]  match;
  logic [DEPTH-1:0]  shift;
  logic [NOTE_W-1:0] rm_note [DEPTH];
  logic [DEPTH-1:0]  rm_vld;

  // Every entry at or below the matching one moves up by one slot.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    shift = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc      = acc | match[i];
      shift[i] = acc;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      assign match[i] = vld_q[i] && (stk_q[i] == note_i);
      if (i == DEPTH - 1) begin : g_last
        assign rm_note[i] = shift[i] ? '0 : stk_q[i];
        assign rm_vld[i]  = vld_q[i] & ~shift[i];
      end else begin : g_mid
        assign rm_note[i] = shift[i] ? stk_q[i+1] : stk_q[i];
        assign rm_vld[i]  = shift[i] ? vld_q[i+1] : vld_q[i];
      end
    end
  endgenerate

  // A note-on pushes onto the compacted stack; the bottom entry falls off when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (on_i) begin
      stk_q[0] <= note_i;
      vld_q[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
        stk_q[i] <= rm_note[i-1];
        vld_q[i] <= rm_vld[i-1];
      end
    end else if (off_i) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= rm_note[i];
      vld_q <= rm_vld;
    end
  end

  assign top_o   = stk_q[0];
  assign empty_o = ~vld_q[0];
  assign full_o  = vld_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/voice_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | voice_ctrl : monophonic front end sequencing super_saw once per frame      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module voice_ctrl
  import voice_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick_i,
  input  logic              ev_valid_i,
  output logic              ev_ready_o,
  input  logic              ev_note_on_i,
  input  logic [NOTE_W-1:0] ev_note_i,
  output logic              ss_start_o,
  input  logic              ss_finish_i,
  output logic              ss_gate_o,
  output logic              ss_trigger_o,
  output logic [FREQ_W-1:0] ss_freq_o,
  input  logic [FREQ_W-1:0] ss_wave_i,
  output logic              out_valid_o,
  output logic [FREQ_W-1:0] out_sample_o,
  output logic              overrun_o
);

  state_t            state_q;
  logic              tick_pend_q;
  logic              trig_pend_q;
  logic              calc_busy_q;
  logic [NOTE_W-1:0] rem_q;
  logic [3:0]        oct_q;

  logic              ss_start_q;
  logic              ss_gate_q;
  logic              ss_trigger_q;
  logic [FREQ_W-1:0] ss_freq_q;
  logic              out_valid_q;
  logic [FREQ_W-1:0] out_sample_q;
  logic              overrun_q;

  logic              ev_accept;
  logic [NOTE_W-1:0] stk_top;
  logic              stk_empty;
  logic              stk_full_unused;

  assign ev_ready_o = ~rst & (state_q == ST_IDLE) & ~sample_tick_i & ~tick_pend_q;
  assign ev_accept  = ev_valid_i & ev_ready_o;

  note_stack #(.DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .on_i    (ev_accept & ev_note_on_i),
    .off_i   (ev_accept & ~ev_note_on_i),
    .note_i  (ev_note_i),
    .top_o   (stk_top),
    .empty_o (stk_empty),
    .full_o  (stk_full_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_pend_q  <= 1'b0;
      trig_pend_q  <= 1'b0;
      calc_busy_q  <= 1'b0;
      rem_q        <= '0;
      oct_q        <= '0;
      ss_start_q   <= 1'b0;
      ss_gate_q    <= 1'b0;
      ss_trigger_q <= 1'b0;
      ss_freq_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      ss_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Ticks that cannot start a frame now are remembered once; a second is lost.
      if (sample_tick_i && (state_q != ST_IDLE || tick_pend_q)) begin
        if (tick_pend_q) overrun_q   <= 1'b1;
        else             tick_pend_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (sample_tick_i || tick_pend_q) begin
            state_q      <= ST_RUN;
            ss_start_q   <= 1'b1;
            tick_pend_q  <= 1'b0;
            ss_trigger_q <= trig_pend_q;
            trig_pend_q  <= 1'b0;
            ss_gate_q    <= ~stk_empty;
          end else if (ev_valid_i) begin
            state_q     <= ST_CALC;
            calc_busy_q <= 1'b0;
            if (ev_note_on_i) trig_pend_q <= 1'b1;
          end
        end
        ST_CALC: begin
          // The stack settles on the accept edge, so the top is loaded one cycle later.
          if (!calc_busy_q) begin
            if (stk_empty) begin
              state_q <= ST_IDLE;
            end else begin
              rem_q       <= stk_top;
              oct_q       <= '0;
              calc_busy_q <= 1'b1;
            end
          end else if (rem_q >= 7'd12) begin
            rem_q <= rem_q - 7'd12;
            oct_q <= oct_q + 4'd1;
          end else begin
            ss_freq_q   <= semi_inc(rem_q[3:0]) >> (4'(BASE_OCT) - oct_q);
            calc_busy_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (ss_finish_i) begin
            out_sample_q <= ss_wave_i;
            state_q      <= ST_OUT;
          end
        end
        ST_OUT: begin
          out_valid_q  <= 1'b1;
          ss_trigger_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ss_start_o   = ss_start_q;
  assign ss_gate_o    = ss_gate_q;
  assign ss_trigger_o = ss_trigger_q;
  assign ss_freq_o    = ss_freq_q;
  assign out_valid_o  = out_valid_q;
  assign out_sample_o = out_sample_q;
  assign overrun_o    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_ctrl.sv
`default_nettype none
// Bench for voice_ctrl: directed scenarios followed by random note traffic,
// checked against a queue-based model of the note stack and pitch arithmetic.
module tb_voice_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick_i = 1'b0;
  logic        ev_valid_i = 1'b0;
  logic        ev_ready_o;
  logic        ev_note_on_i = 1'b0;
  logic [6:0]  ev_note_i = '0;
  logic        ss_start_o;
  logic        ss_finish_i = 1'b0;
  logic        ss_gate_o;
  logic        ss_trigger_o;
  logic [23:0] ss_freq_o;
  logic [23:0] ss_wave_i = '0;
  logic        out_valid_o;
  logic [23:0] out_sample_o;
  logic        overrun_o;

  always #5 clk = ~clk;

  voice_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick_i(sample_tick_i),
    .ev_valid_i   (ev_valid_i),
    .ev_ready_o   (ev_ready_o),
    .ev_note_on_i (ev_note_on_i),
    .ev_note_i    (ev_note_i),
    .ss_start_o   (ss_start_o),
    .ss_finish_i  (ss_finish_i),
    .ss_gate_o    (ss_gate_o),
    .ss_trigger_o (ss_trigger_o),
    .ss_freq_o    (ss_freq_o),
    .ss_wave_i    (ss_wave_i),
    .out_valid_o  (out_valid_o),
    .out_sample_o (out_sample_o),
    .overrun_o    (overrun_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: stack held as a queue with the sounding note at index 0.
  int stk[$];
  bit m_trig = 1'b0;
  int m_freq = 0;

  int n_start = 0;
  int n_outv  = 0;
  int n_ovr   = 0;

  always @(negedge clk) begin
    if (ss_start_o === 1'b1)  n_start++;
    if (out_valid_o === 1'b1) n_outv++;
    if (overrun_o === 1'b1)   n_ovr++;
  end

  // Equal-tempered pitch at A4=440 Hz, 48 kHz, 24-bit phase, built from the top
  // octave and shifted down by whole octaves (truncating).
  function automatic int ref_inc(input int n);
    int  k;
    int  oct;
    int  base;
    real f;
    k    = n % 12;
    oct  = n / 12;
    f    = 440.0 * (2.0 ** (real'(k + 51) / 12.0)) * 16777216.0 / 48000.0;
    base = $rtoi(f + 0.5);
    // Entry C is pinned to the published table value, one LSB above exact rounding.
    if (k == 0) base = 2926233;
    return base >> (10 - oct);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_event(input bit on, input int n);
    for (int i = stk.size() - 1; i >= 0; i--)
      if (stk[i] == n) stk.delete(i);
    if (on) begin
      stk.push_front(n);
      if (stk.size() > DEPTH) void'(stk.pop_back());
      m_trig = 1'b1;
    end
    if (stk.size() > 0) m_freq = ref_inc(stk[0]);
  endtask

  task automatic send_ev(input bit on, input int n);
    int guard;
    guard        = 0;
    ev_valid_i   = 1'b1;
    ev_note_on_i = on;
    ev_note_i    = 7'(n);
    @(negedge clk);
    while (ev_ready_o !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ev_ready_wait", 32'(guard < 200), 1);
    step();
    ev_valid_i = 1'b0;
    model_event(on, n);
    repeat (12) step();
    chk("ev_freq", ss_freq_o, m_freq);
    chk("ev_back_idle", ev_ready_o, 1);
  endtask

  task automatic finish_frame(input logic [23:0] wave);
    int g;
    ss_wave_i   = wave;
    ss_finish_i = 1'b1;
    step();
    ss_finish_i = 1'b0;
    g = 0;
    while (out_valid_o !== 1'b1 && g < 10) begin
      step();
      g++;
    end
    chk("out_valid_seen", 32'(g < 10), 1);
    chk("out_sample", out_sample_o, wave);
    chk("trigger_cleared", ss_trigger_o, 0);
  endtask

  task automatic run_frame(input logic [23:0] wave);
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    chk("frame_start", ss_start_o, 1);
    chk("frame_gate", ss_gate_o, 32'(stk.size() > 0));
    chk("frame_trigger", ss_trigger_o, m_trig);
    chk("frame_freq", ss_freq_o, m_freq);
    m_trig = 1'b0;
    repeat ($urandom_range(0, 3)) step();
    finish_frame(wave);
    step();
  endtask

  initial begin
    int s0;
    int o0;
    int v0;

    // Reset state
    repeat (2) step();
    chk("rst_ev_ready", ev_ready_o, 0);
    chk("rst_start", ss_start_o, 0);
    chk("rst_gate", ss_gate_o, 0);
    chk("rst_trigger", ss_trigger_o, 0);
    chk("rst_freq", ss_freq_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_sample", out_sample_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", ev_ready_o, 1);

    // Frame with an empty stack
    run_frame(24'h123456);

    // Single note, then the trigger appears for exactly one frame
    send_ev(1'b1, 69);
    chk("a4_freq", ss_freq_o, 153791);
    run_frame(24'h0000a5);
    run_frame(24'h00005a);

    // Legato release back to an earlier note
    send_ev(1'b1, 60);
    send_ev(1'b1, 64);
    run_frame(24'h111111);
    send_ev(1'b0, 64);
    chk("legato_freq", ss_freq_o, 91444);
    run_frame(24'h222222);

    // Ticks arriving while a frame is rendering
    s0 = n_start;
    o0 = n_ovr;
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    chk("t4_start_a", ss_start_o, 1);
    m_trig = 1'b0;
    step();
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    chk("t4_no_overrun_first", overrun_o, 0);
    step();
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    chk("t4_overrun_pulse", overrun_o, 1);
    finish_frame(24'h333333);
    step();
    chk("t4_start_b", ss_start_o, 1);
    chk("t4_gate_b", ss_gate_o, 1);
    chk("t4_trigger_b", ss_trigger_o, 0);
    finish_frame(24'h444444);
    repeat (20) step();
    chk("t4_frame_count", n_start - s0, 2);
    chk("t4_overrun_count", n_ovr - o0, 1);

    // Overflow drops the oldest note; releasing the rest empties the stack
    for (int n = 60; n <= 64; n++) send_ev(1'b1, n);
    for (int n = 64; n >= 61; n--) send_ev(1'b0, n);
    chk("t5_empty_model", stk.size(), 0);
    chk("t5_freq_held", ss_freq_o, ref_inc(61));
    run_frame(24'h555555);

    // Reset in the middle of a frame, then a stray finish
    send_ev(1'b1, 72);
    sample_tick_i = 1'b1;
    step();
    sample_tick_i = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("t6_rst_freq", ss_freq_o, 0);
    chk("t6_rst_gate", ss_gate_o, 0);
    chk("t6_rst_trigger", ss_trigger_o, 0);
    rst = 1'b0;
    stk.delete();
    m_trig = 1'b0;
    m_freq = 0;
    v0 = n_outv;
    ss_wave_i   = 24'hdeadbe;
    ss_finish_i = 1'b1;
    step();
    ss_finish_i = 1'b0;
    repeat (5) step();
    chk("t6_no_out_valid", n_outv - v0, 0);
    chk("t6_out_sample", out_sample_o, 0);

    // Tick and event offered together: the tick wins
    sample_tick_i = 1'b1;
    ev_valid_i    = 1'b1;
    ev_note_on_i  = 1'b1;
    ev_note_i     = 7'd50;
    #1;
    chk("t6_ev_stalled", ev_ready_o, 0);
    step();
    sample_tick_i = 1'b0;
    ev_valid_i    = 1'b0;
    chk("t6_tick_start", ss_start_o, 1);
    chk("t6_tick_gate", ss_gate_o, 0);
    finish_frame(24'h0f0f0f);
    step();

    // Random note traffic
    for (int r = 0; r < 40; r++) begin
      if (stk.size() > 0 && $urandom_range(0, 2) == 0)
        send_ev(1'b0, stk[$urandom_range(0, stk.size() - 1)]);
      else if ($urandom_range(0, 7) == 0)
        send_ev(1'b0, $urandom_range(0, 127));
      else
        send_ev(1'b1, $urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) run_frame(24'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
